// File: rtl/des_decrypt_key_schedule.sv
// DES key schedule for decryption: emits K16 down to K1, one subkey per
// valid/ready transfer, by rotating the PC-1 halves right.
module des_decrypt_key_schedule (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [63:0] key_in,
   input  logic        subkey_ready,
   output logic [47:0] subkey_out,
   output logic        subkey_valid,
   output logic [3:0]  subkey_num,
   output logic        busy,
   output logic        done
);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t      state;
   logic [27:0] c;
   logic [27:0] d;
   logic        rot_one;

   // Table entries are FIPS bit numbers; FIPS bit 1 is the MSB of each vector.
   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      logic [5:0]  src;
      logic [5:0]  dst;
      r = '0;
      for (int i = 0; i < 56; i++) begin
         src    = 6'(64 - PC1_TAB[i]);
         dst    = 6'(55 - i);
         r[dst] = k[src];
      end
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      logic [5:0]  src;
      logic [5:0]  dst;
      r = '0;
      for (int i = 0; i < 48; i++) begin
         src    = 6'(56 - PC2_TAB[i]);
         dst    = 6'(47 - i);
         r[dst] = cd[src];
      end
      return r;
   endfunction

   // Single-step moves are K16->K15, K9->K8 and K2->K1; every other step is two.
   assign rot_one = (subkey_num == 4'd15) || (subkey_num == 4'd8) || (subkey_num == 4'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         c          <= '0;
         d          <= '0;
         subkey_num <= 4'd0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  {c, d}     <= pc1(key_in);
                  subkey_num <= 4'd15;
                  state      <= EMIT;
               end
            end
            EMIT: begin
               if (subkey_ready) begin
                  if (subkey_num == 4'd0) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end else begin
                     c          <= rot_one ? {c[0], c[27:1]} : {c[1:0], c[27:2]};
                     d          <= rot_one ? {d[0], d[27:1]} : {d[1:0], d[27:2]};
                     subkey_num <= subkey_num - 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Valid/ready: a subkey transfers on any cycle where subkey_valid and
   // subkey_ready are both high; otherwise every output holds.
   assign subkey_valid = (state == EMIT);
   assign busy         = (state == EMIT);
   assign subkey_out   = pc2({c, d});

endmodule

// File: tb/tb_des_decrypt_key_schedule.sv
// Directed bench for des_decrypt_key_schedule using the classic
// 133457799BBCDFF1 key and its published K1..K16 subkeys.
module tb_des_decrypt_key_schedule;

   logic        clk;
   logic        reset;
   logic        start;
   logic [63:0] key_in;
   logic        subkey_ready;
   logic [47:0] subkey_out;
   logic        subkey_valid;
   logic [3:0]  subkey_num;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   logic [47:0] exp_q[$];

   localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_PAR = 64'h123556789ABDDEF0;

   // Encryption-order subkeys K1..K16 for KEY_A (index 0 = K1).
   logic [47:0] kenc [16] = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
   };

   des_decrypt_key_schedule dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .key_in       (key_in),
      .subkey_ready (subkey_ready),
      .subkey_out   (subkey_out),
      .subkey_valid (subkey_valid),
      .subkey_num   (subkey_num),
      .busy         (busy),
      .done         (done)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load_known();
      for (int i = 15; i >= 0; i--) exp_q.push_back(kenc[i]);
   endtask

   task automatic load_zero();
      for (int i = 0; i < 16; i++) exp_q.push_back(48'h0);
   endtask

   task automatic do_start(input logic [63:0] key);
      start  = 1'b1;
      key_in = key;
      @(negedge clk);
   endtask

   // Called at the negedge of the first EMIT cycle. Consumes the schedule,
   // applying stalls, an optional start-while-busy pulse and an optional abort.
   task automatic drain(input int stall_a_num, input int stall_a_len,
                        input int stall_b_num, input int stall_b_len,
                        input int busy_num, input logic [63:0] busy_key,
                        input int abort_num, input bit chain,
                        input logic [63:0] chain_key, input int done_cyc);
      int exp_num  = 15;
      int cyc      = 1;
      int left_a   = stall_a_len;
      int left_b   = stall_b_len;
      bit last     = 1'b0;
      bit finished = 1'b0;
      bit pulsed   = 1'b0;
      while (!finished && cyc < 200) begin
         start = 1'b0;
         if (last) begin
            check("done", 64'(done), 64'd1);
            check("valid_after_k1", 64'(subkey_valid), 64'd0);
            check("done_cycle", 64'(cyc), 64'(done_cyc));
            if (chain) begin
               start  = 1'b1;
               key_in = chain_key;
            end
            finished = 1'b1;
         end else begin
            check("valid", 64'(subkey_valid), 64'd1);
            check("busy", 64'(busy), 64'd1);
            check("no_early_done", 64'(done), 64'd0);
            check("num", 64'(subkey_num), 64'(exp_num));
            check("subkey", 64'(subkey_out), 64'(exp_q[0]));
            if (exp_num == abort_num) begin
               finished = 1'b1;
            end else begin
               if (exp_num == stall_a_num && left_a > 0) begin
                  subkey_ready = 1'b0;
                  left_a--;
               end else if (exp_num == stall_b_num && left_b > 0) begin
                  subkey_ready = 1'b0;
                  left_b--;
               end else begin
                  subkey_ready = 1'b1;
               end
               if (exp_num == busy_num && !pulsed) begin
                  start  = 1'b1;
                  key_in = busy_key;
                  pulsed = 1'b1;
               end
               if (subkey_ready) begin
                  void'(exp_q.pop_front());
                  if (exp_num == 0) last = 1'b1;
                  else exp_num--;
               end
            end
         end
         if (!finished) begin
            @(negedge clk);
            cyc++;
         end
      end
      check("drain_timeout", 64'(finished), 64'd1);
   endtask

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      key_in       = 64'h0;
      subkey_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_valid", 64'(subkey_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_num", 64'(subkey_num), 64'd0);
      check("rst_subkey", 64'(subkey_out), 64'd0);

      // known vector, ready always high
      load_known();
      do_start(KEY_A);
      drain(-1, 0, -1, 0, -1, 64'h0, -1, 1'b0, 64'h0, 17);
      @(negedge clk);

      // parity bits flipped, stalls at K9 and K1, chained into an all-zero key
      load_known();
      do_start(KEY_PAR);
      drain(8, 3, 0, 5, -1, 64'h0, -1, 1'b1, 64'h0, 25);
      @(negedge clk);
      load_zero();
      drain(-1, 0, -1, 0, 10, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1'b0, 64'h0, 17);
      @(negedge clk);

      // reset in the middle of a schedule, with start held in the same cycle
      load_known();
      do_start(KEY_A);
      drain(-1, 0, -1, 0, -1, 64'h0, 6, 1'b0, 64'h0, 0);
      exp_q.delete();
      reset        = 1'b1;
      start        = 1'b1;
      key_in       = KEY_A;
      subkey_ready = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 64'(subkey_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_num", 64'(subkey_num), 64'd0);
      check("mid_rst_subkey", 64'(subkey_out), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("post_rst_valid", 64'(subkey_valid), 64'd0);
      check("post_rst_done", 64'(done), 64'd0);

      load_known();
      do_start(KEY_A);
      drain(-1, 0, -1, 0, -1, 64'h0, -1, 1'b0, 64'h0, 17);
      @(negedge clk);
      check("idle_valid", 64'(subkey_valid), 64'd0);
      check("idle_done", 64'(done), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
